// File: rtl/mac_nbits_pkg.sv
// Shared constants and width helpers for the signed multiply-accumulate unit.
package mac_nbits_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // The accumulator is exactly wide enough to hold any operand product.
  function automatic int acc_width(input int operand_width);
    return 2 * operand_width;
  endfunction

endpackage

// File: rtl/mac_nbits_if.sv
// Operand/result bundle between a lane controller (master) and the MAC (slave).
interface mac_nbits_if
  import mac_nbits_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 en;
  logic [WIDTH-1:0]     w;
  logic [WIDTH-1:0]     x;
  logic [2*WIDTH-1:0]   out;

  modport master (output en, output w, output x, input out);
  modport slave  (input en, input w, input x, output out);

endinterface

// File: rtl/rca_nbits.sv
// Parameterized ripple-carry adder built from one full-adder cell per bit.
module rca_nbits
  import mac_nbits_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule

// File: rtl/mac_nbits.sv
// Signed multiply-accumulate: acc <= acc + w*x on enabled edges, wrapping modulo 2^(2*WIDTH).
module mac_nbits
  import mac_nbits_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  mac_nbits_if.slave   bus
);

  localparam int AccW = acc_width(WIDTH);

  logic [AccW-1:0] w_ext;
  logic [AccW-1:0] x_ext;
  logic [AccW-1:0] prod;
  logic [AccW-1:0] sum;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] acc_d;
  logic            unused_cout;

  // Sign-extending both operands to the full width makes an unsigned
  // multiply bit-exact for signed values, modulo 2^AccW.
  assign w_ext = {{WIDTH{bus.w[WIDTH-1]}}, bus.w};
  assign x_ext = {{WIDTH{bus.x[WIDTH-1]}}, bus.x};
  assign prod  = w_ext * x_ext;

  // Carry-out is dropped: accumulation wraps by design.
  rca_nbits #(
    .WIDTH (AccW)
  ) u_rca (
    .a    (acc_q),
    .b    (prod),
    .cin  (1'b0),
    .sum  (sum),
    .cout (unused_cout)
  );

  always_comb begin
    acc_d = acc_q;
    if (bus.en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.out = acc_q;

endmodule

// File: tb/tb_mac_nbits.sv
// Self-checking bench for mac_nbits: directed scenarios plus a randomized run against a reference model.
module tb_mac_nbits;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   model_acc;

  mac_nbits_if #(.WIDTH(8)) bus ();

  mac_nbits #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input bit r, input bit e, input int wv, input int xv);
    rst    = r;
    bus.en = e;
    bus.w  = wv[7:0];
    bus.x  = xv[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer accumulate, folded into the signed 16-bit range.
  function automatic int wrap16(input int v);
    int m;
    m = v & 32'hFFFF;
    if (m >= 32768) m = m - 65536;
    return m;
  endfunction

  task automatic test_reset();
    apply(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.out !== 16'd0) begin
        errors++;
        $display("FAIL reset_edge%0d: out=%0d expected 0", i, $signed(bus.out));
      end
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      tick();
      checks++;
      if (bus.out !== 16'd0) begin
        errors++;
        $display("FAIL idle_after_reset%0d: out=%0d expected 0", i, $signed(bus.out));
      end
    end
  endtask

  task automatic test_accumulate();
    apply(0, 1, -3, 2);
    tick();
    checks++;
    if (bus.out !== 16'(-6)) begin
      errors++;
      $display("FAIL acc_first: out=%0d expected -6", $signed(bus.out));
    end
    apply(0, 1, 5, -4);
    tick();
    checks++;
    if (bus.out !== 16'(-26)) begin
      errors++;
      $display("FAIL acc_second: out=%0d expected -26", $signed(bus.out));
    end
  endtask

  task automatic test_reset_priority();
    apply(1, 1, 7, 7);
    tick();
    checks++;
    if (bus.out !== 16'd0) begin
      errors++;
      $display("FAIL reset_over_en: out=%0d expected 0", $signed(bus.out));
    end
  endtask

  task automatic test_hold();
    apply(1, 0, 0, 0);
    tick();
    apply(0, 1, 6, -8);
    tick();
    checks++;
    if (bus.out !== 16'(-48)) begin
      errors++;
      $display("FAIL hold_load: out=%0d expected -48", $signed(bus.out));
    end
    apply(0, 0, -8, -4);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out !== 16'(-48)) begin
        errors++;
        $display("FAIL hold_edge%0d: out=%0d expected -48", i, $signed(bus.out));
      end
    end
    apply(0, 1, -8, -4);
    tick();
    checks++;
    if (bus.out !== 16'(-16)) begin
      errors++;
      $display("FAIL hold_resume: out=%0d expected -16", $signed(bus.out));
    end
  endtask

  task automatic test_extremes();
    apply(1, 0, 0, 0);
    tick();
    apply(0, 1, -128, -128);
    tick();
    checks++;
    if (bus.out !== 16'd16384) begin
      errors++;
      $display("FAIL ext_min_sq: out=%0d expected 16384", $signed(bus.out));
    end
    tick();
    checks++;
    if (bus.out !== 16'h8000) begin
      errors++;
      $display("FAIL ext_wrap: out=%0d expected -32768", $signed(bus.out));
    end
    tick();
    checks++;
    if (bus.out !== 16'(-16384)) begin
      errors++;
      $display("FAIL ext_third: out=%0d expected -16384", $signed(bus.out));
    end
    apply(1, 0, 0, 0);
    tick();
    apply(0, 1, -128, 127);
    tick();
    checks++;
    if (bus.out !== 16'(-16256)) begin
      errors++;
      $display("FAIL ext_min_max: out=%0d expected -16256", $signed(bus.out));
    end
  endtask

  task automatic test_random();
    int  wv;
    int  xv;
    bit  r;
    bit  e;
    int  local_errs;
    local_errs = 0;
    apply(1, 0, 0, 0);
    tick();
    model_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      wv = int'($urandom_range(0, 255)) - 128;
      xv = int'($urandom_range(0, 255)) - 128;
      e  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 49) == 0);
      apply(r, e, wv, xv);
      if (r) model_acc = 0;
      else if (e) model_acc = wrap16(model_acc + wv * xv);
      tick();
      checks++;
      if (bus.out !== 16'(model_acc)) begin
        errors++;
        local_errs++;
        if (local_errs <= 10)
          $display("FAIL random_cycle%0d: out=%0d expected %0d (rst=%0b en=%0b w=%0d x=%0d)",
                   i, $signed(bus.out), model_acc, r, e, wv, xv);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    apply(1, 0, 0, 0);
    test_reset();
    test_accumulate();
    test_reset_priority();
    test_hold();
    test_extremes();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
